ps2_kbd_rx: RTL

PS/2 keyboard receiver that consumes the serial `ps2_clk`/`ps2_data` pair produced by the HPS keyboard emulation and delivers decoded scan-code events to the Microcomputer's keyboard/terminal logic. It synchronises and deglitches the PS/2 lines, deserialises and checks 11-bit frames, and folds `E0` (extended) and `F0` (release) prefixes into per-event flags. Results are buffered in a small FIFO behind a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_event_fifo.sv | 56 +++++
 rtl/ps2_kbd_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared types.
// Event bundle, FSM states and prefix codes.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  // Odd parity over data plus parity bit.
  function automatic logic frame_ok(
    input logic [7:0] data,
    input logic       par,
    input logic       stop
  );
    return stop & (^{data, par});
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Event FIFO for the PS/2 receiver.
// Register-array storage, simultaneous push/pop.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ps2_event_t push_ev,
  input  logic       pop,
  output ps2_event_t head,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ps2_event_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr;
  logic              rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign drop  = push & full & ~rd;
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync, filter, frame FSM,
// E0/F0 prefix folding and event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER      = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk_sys,
  input  logic       RESET_N,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] code_data,
  output logic       code_ext,
  output logic       code_rel,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          dat;

  ps2_state_e    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          ext_q;
  logic          rel_q;

  logic          good;
  logic          push;
  ps2_event_t    push_ev;
  ps2_event_t    head;
  logic          empty;
  logic          full;

  assign dat  = dat_sync[1];
  assign fall = filt & ~clk_sync[1] &
                (filt_cnt == FW'(FILTER - 1));

  // Two-flop synchronisers on both PS/2 lines.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Clock deglitch: level changes after FILTER equal samples.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER - 1)) begin
      filt     <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign good    = (state == ST_STOP) & fall &
                   frame_ok(shreg, par, dat);
  assign push    = good & (shreg != PS2_EXT) &
                   (shreg != PS2_REL);
  assign push_ev = '{ext: ext_q, rel: rel_q, code: shreg};

  // Frame FSM with timeout and prefix flags.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      if (state == ST_IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYC))
        to_cnt <= to_cnt + 1'b1;
      if (state != ST_IDLE && !fall &&
          to_cnt == TW'(TIMEOUT_CYC)) begin
        state       <= ST_IDLE;
        err_timeout <= 1'b1;
        ext_q       <= 1'b0;
        rel_q       <= 1'b0;
      end else if (fall) begin
        case (state)
          ST_IDLE: if (!dat) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= dat;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!good) begin
              err_frame <= 1'b1;
              ext_q     <= 1'b0;
              rel_q     <= 1'b0;
            end else if (shreg == PS2_EXT) begin
              ext_q <= 1'b1;
            end else if (shreg == PS2_REL) begin
              rel_q <= 1'b1;
            end else begin
              ext_q <= 1'b0;
              rel_q <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .rst_n   (RESET_N),
    .push    (push),
    .push_ev (push_ev),
    .pop     (code_ready),
    .head    (head),
    .empty   (empty),
    .full    (full),
    .drop    (overflow)
  );

  assign code_valid = ~empty;
  assign code_data  = head.code;
  assign code_ext   = head.ext;
  assign code_rel   = head.rel;

endmodule
